// File: rtl/bit_serializer.sv
// bit_serializer: parallel word in over valid/ready, one bit per clock out, optional idle gap and frame counter.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0,
  parameter int IDLE_LEVEL = 0,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               serial_out,
  output logic               serial_valid,
  output logic               frame_done,
  output logic [COUNT_W-1:0] frame_count
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] gap_q, gap_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic serial_out_q, serial_out_d, serial_valid_q, serial_valid_d, frame_done_q, frame_done_d;
  logic [COUNT_W-1:0] frame_count_q, frame_count_d;
  logic last, take;
  always_comb begin
    last = state_q == SHIFT && cnt_q == CW'(WIDTH-1);
    data_ready = !reset && (state_q == IDLE || (last && GAP_CYCLES == 0));
    take = data_valid && data_ready;
    state_d = state_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    shreg_d = shreg_q;
    frame_done_d = last;
    frame_count_d = frame_count_q + COUNT_W'(last);
    if (take) begin
      state_d = SHIFT;
      cnt_d = '0;
      shreg_d = data_in;
    end else if (state_q == SHIFT) begin
      shreg_d = MSB_FIRST != 0 ? shreg_q << 1 : shreg_q >> 1;
      cnt_d = cnt_q + 1'b1;
      gap_d = '0;
      if (last) state_d = GAP_CYCLES > 0 ? GAP : IDLE;
    end else if (state_q == GAP) begin
      gap_d = gap_q + 8'd1;
      if (gap_q == 8'(GAP_CYCLES-1)) state_d = IDLE;
    end
    // outputs are registered, so they are derived from the state being entered
    serial_valid_d = state_d == SHIFT;
    serial_out_d = state_d == SHIFT ? (MSB_FIRST != 0 ? shreg_d[WIDTH-1] : shreg_d[0]) : 1'(IDLE_LEVEL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gap_q <= '0;
      shreg_q <= '0;
      serial_out_q <= 1'(IDLE_LEVEL);
      serial_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      shreg_q <= shreg_d;
      serial_out_q <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_done_q <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign serial_out = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_done = frame_done_q;
  assign frame_count = frame_count_q;
endmodule
